mux_sel_scanner: RTL and testbench



---
 rtl/mux_sel_scanner.sv | 99 +++++++++
 tb/tb_mux_sel_scanner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_scanner.sv
// Steps a 4:1 mux select through channels 0..3. Each channel settles for SETTLE cycles before
// it is sampled. The four samples are presented as one word on a valid/ready handshake.
module mux_sel_scanner #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] mux_sel,
  input  logic       mux_out,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       overrun
);

  // state | meaning
  // IDLE  | waiting for start, mux_sel parked at 0
  // SCAN  | stepping mux_sel, settle counter running
  // HOLD  | word complete, waiting for valid&&ready
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shadow  <= '0;
      mux_sel <= 2'd0;
      data    <= 4'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          mux_sel <= 2'd0;
          if (start) begin
            state <= SCAN;
            cnt   <= RELOAD;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (start) overrun <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            case (mux_sel)
              2'd0: shadow[0] <= mux_out;
              2'd1: shadow[1] <= mux_out;
              2'd2: shadow[2] <= mux_out;
              default: ;
            endcase
            if (mux_sel != 2'd3) begin
              mux_sel <= mux_sel + 2'd1;
              cnt     <= RELOAD;
            end else begin
              // The channel-3 bit bypasses the shadow, so the word is ready on this edge.
              data  <= {mux_out, shadow};
              valid <= 1'b1;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (ready) begin
            valid   <= 1'b0;
            mux_sel <= 2'd0;
            if (start) begin
              state <= SCAN;
              cnt   <= RELOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (start) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          valid   <= 1'b0;
          mux_sel <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Randomized and directed bench for mux_sel_scanner with SETTLE=1 and SETTLE=3 instances.
// Each instance is checked against an elapsed-time reference model.
module tb_mux_sel_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] mux_in [2];

  logic [1:0] sel1, sel3;
  logic [3:0] data1, data3;
  logic       valid1, valid3, busy1, busy3, ovr1, ovr3;
  logic       mux_out1, mux_out3;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign mux_out1 = mux_in[0][sel1];
  assign mux_out3 = mux_in[1][sel3];

  mux_sel_scanner #(.SETTLE(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mux_sel(sel1), .mux_out(mux_out1),
    .data(data1), .valid(valid1), .ready(ready), .busy(busy1), .overrun(ovr1));

  mux_sel_scanner #(.SETTLE(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .mux_sel(sel3), .mux_out(mux_out3),
    .data(data3), .valid(valid3), .ready(ready), .busy(busy3), .overrun(ovr3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a scan accepted at edge t0 samples channel i at edge t0+(i+1)*S.
  int         s_val [2] = '{1, 3};
  int         tcnt;
  int         t0     [2];
  bit         m_busy [2];
  bit         m_hold [2];
  bit         m_valid[2];
  bit         m_ovr  [2];
  logic [1:0] m_sel  [2];
  logic [3:0] m_word [2];
  logic [3:0] m_data [2];

  task automatic model_step(input int k);
    int el, ch;
    m_ovr[k] = 1'b0;
    if (!m_busy[k]) begin
      if (start) begin
        m_busy[k] = 1'b1;
        m_hold[k] = 1'b0;
        t0[k]     = tcnt;
        m_sel[k]  = 2'd0;
      end
    end else if (!m_hold[k]) begin
      if (start) m_ovr[k] = 1'b1;
      el = tcnt - t0[k];
      if (el % s_val[k] == 0) begin
        ch = el / s_val[k] - 1;
        m_word[k][ch] = mux_in[k][ch];
        if (ch == 3) begin
          m_data[k]  = m_word[k];
          m_valid[k] = 1'b1;
          m_hold[k]  = 1'b1;
        end else begin
          m_sel[k] = 2'(ch + 1);
        end
      end
    end else begin
      if (ready) begin
        m_valid[k] = 1'b0;
        m_sel[k]   = 2'd0;
        m_hold[k]  = 1'b0;
        if (start) t0[k] = tcnt;
        else m_busy[k] = 1'b0;
      end else if (start) begin
        m_ovr[k] = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt = 0;
      for (int k = 0; k < 2; k++) begin
        t0[k] = 0; m_busy[k] = 0; m_hold[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
        m_sel[k] = 2'd0; m_word[k] = 4'd0; m_data[k] = 4'd0;
      end
    end else begin
      tcnt++;
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sel1",   32'(sel1),   32'(m_sel[0]));
      check("valid1", 32'(valid1), 32'(m_valid[0]));
      check("busy1",  32'(busy1),  32'(m_busy[0]));
      check("ovr1",   32'(ovr1),   32'(m_ovr[0]));
      check("data1",  32'(data1),  32'(m_data[0]));
      check("sel3",   32'(sel3),   32'(m_sel[1]));
      check("valid3", 32'(valid3), 32'(m_valid[1]));
      check("busy3",  32'(busy3),  32'(m_busy[1]));
      check("ovr3",   32'(ovr3),   32'(m_ovr[1]));
      check("data3",  32'(data3),  32'(m_data[1]));
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    mux_in[0] = 4'd0;
    mux_in[1] = 4'd0;
    start = 1'b1;
    #3 rst_n = 1'b0;
    chk_en = 1'b1;
    cyc(3);
    check("rst_sel3",  32'(sel3),   32'd0);
    check("rst_valid", 32'(valid3), 32'd0);
    check("rst_data1", 32'(data1),  32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    cyc(4);
    check("idle_busy1", 32'(busy1), 32'd0);

    // Basic scan on both instances.
    mux_in[0] = 4'b1010;
    mux_in[1] = 4'b0110;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(4);
    mux_in[1][0] = 1'b1;
    n = 0;
    while (!valid3 && n < 40) begin cyc(); n++; end
    check("wait_valid3", 32'(valid3), 32'd1);
    check("word3", 32'(data3), 32'(4'b0110));
    check("word1", 32'(data1), 32'(4'b1010));
    cyc(3);
    check("hold_valid1", 32'(valid1), 32'd1);
    ready = 1'b1;
    cyc();
    check("ack_valid1", 32'(valid1), 32'd0);
    ready = 1'b0;

    // Back-to-back with start and ready held.
    mux_in[0] = 4'b1111;
    start = 1'b1;
    ready = 1'b1;
    n = 0;
    while (!valid1 && n < 40) begin cyc(); n++; end
    check("b2b_valid_a", 32'(valid1), 32'd1);
    check("b2b_word_a", 32'(data1), 32'(4'b1111));
    mux_in[0] = 4'b0001;
    cyc();
    n = 0;
    while (!valid1 && n < 40) begin cyc(); n++; end
    check("b2b_valid_b", 32'(valid1), 32'd1);
    check("b2b_word_b", 32'(data1), 32'(4'b0001));
    start = 1'b0;
    cyc(30);

    // Overrun while the SETTLE=3 scan is on channel 2.
    ready = 1'b0;
    mux_in[1] = 4'b1001;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (sel3 != 2'd2 && n < 40) begin cyc(); n++; end
    check("wait_sel3_2", 32'(sel3), 32'd2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("ovr_pulse", 32'(ovr3), 32'd1);
    cyc();
    check("ovr_clear", 32'(ovr3), 32'd0);
    n = 0;
    while (!valid3 && n < 40) begin cyc(); n++; end
    check("ovr_word3", 32'(data3), 32'(4'b1001));
    ready = 1'b1;
    cyc(3);
    ready = 1'b0;

    // Asynchronous reset mid-scan.
    mux_in[1] = 4'b1111;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (sel3 != 2'd2 && n < 40) begin cyc(); n++; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel3",  32'(sel3),   32'd0);
    check("arst_busy3", 32'(busy3),  32'd0);
    check("arst_data3", 32'(data3),  32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    check("arst_novalid", 32'(valid3), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 9) < 2);
      ready = ($urandom_range(0, 9) < 4);
      mux_in[0] = 4'($urandom);
      mux_in[1] = 4'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
